// File: rtl/sonar_scan_scheduler.sv
// ---------------------------------------------------------------------------
// sonar_scan_scheduler
//
// Round-robin scheduler that shares a single echo-width timer between
// NUM_SENSORS ultrasonic rangers. For each sensor enabled in sensor_mask it
// fires a trigger pulse, waits for the echo to rise, times the echo high
// width (both phases bounded by TIMEOUT_CYCLES), reports the raw width in
// clock cycles and then idles for GUARD_CYCLES so that late reflections from
// one sensor cannot be mistaken for the next sensor's echo.
//
// Ports
//   clk            system clock
//   rst            synchronous active-high reset
//   enable         scanning allowed; a ping in progress always completes
//   sensor_mask    1 = sensor takes part in the scan (sampled when selecting)
//   echo_in        raw asynchronous echo pins, one per sensor
//   trig_out       registered trigger pulses, at most one bit high
//   result_valid   one-cycle pulse when result_* carry a new measurement
//   result_id      index of the sensor that was measured
//   result_cycles  echo high width in clk cycles (0 when no echo was seen)
//   result_timeout measurement hit the timeout limit
//   busy           high whenever the scheduler is not idle
// ---------------------------------------------------------------------------
module sonar_scan_scheduler #(
    parameter int NUM_SENSORS    = 4,
    parameter int ID_W           = 2,
    parameter int CNT_W          = 22,
    parameter int TRIG_CYCLES    = 500,
    parameter int TIMEOUT_CYCLES = 1500000,
    parameter int GUARD_CYCLES   = 3000000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [NUM_SENSORS-1:0] sensor_mask,
    input  logic [NUM_SENSORS-1:0] echo_in,
    output logic [NUM_SENSORS-1:0] trig_out,
    output logic                   result_valid,
    output logic [ID_W-1:0]        result_id,
    output logic [CNT_W-1:0]       result_cycles,
    output logic                   result_timeout,
    output logic                   busy
);

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        TRIG,
        WAIT_RISE,
        MEASURE,
        REPORT,
        GUARD
    } state_t;

    localparam logic [CNT_W-1:0] TRIG_LAST   = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] GUARD_LAST  = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMER_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TIMER_ONE   = CNT_W'(1);
    localparam logic [ID_W-1:0]  LAST_INIT   = ID_W'(NUM_SENSORS - 1);

    state_t                 state;
    state_t                 state_next;

    logic [NUM_SENSORS-1:0] echo_meta;
    logic [NUM_SENSORS-1:0] echo_sync;
    logic [NUM_SENSORS-1:0] echo_dly;
    logic                   echo_rise;
    logic                   echo_fall;

    logic [CNT_W-1:0]       timer;
    logic [CNT_W-1:0]       timer_inc;
    logic [ID_W-1:0]        cur_id;
    logic [ID_W-1:0]        last_id;
    logic [ID_W-1:0]        sel_id;
    logic                   sel_found;
    int                     sel_idx;
    logic [ID_W-1:0]        trig_id;
    logic [NUM_SENSORS-1:0] trig_next;

    // Two-flop synchronizer on every echo pin plus one extra delayed copy
    // for edge detection. The two cycles of latency are left uncompensated
    // because they cancel out between rising and falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            echo_meta <= '0;
            echo_sync <= '0;
            echo_dly  <= '0;
        end else begin
            echo_meta <= echo_in;
            echo_sync <= echo_meta;
            echo_dly  <= echo_sync;
        end
    end

    // Only the currently selected sensor's echo matters; every other pin is
    // ignored no matter what it does.
    assign echo_rise = echo_sync[cur_id] & ~echo_dly[cur_id];
    assign echo_fall = ~echo_sync[cur_id] & echo_dly[cur_id];

    // The timer saturates instead of wrapping so a huge count can never
    // alias back into a plausible small width.
    assign timer_inc = (timer == TIMER_MAX) ? timer : timer + TIMER_ONE;

    // Round-robin pick: first mask bit strictly after last_id, wrapping.
    // Scanning i = 1..NUM_SENSORS means the previous sensor is considered
    // last, so a mask with a single bit keeps re-selecting that sensor.
    always_comb begin
        sel_found = 1'b0;
        sel_id    = last_id;
        sel_idx   = 0;
        for (int i = 1; i <= NUM_SENSORS; i++) begin
            sel_idx = (int'(last_id) + i) % NUM_SENSORS;
            if (!sel_found && sensor_mask[sel_idx]) begin
                sel_found = 1'b1;
                sel_id    = ID_W'(sel_idx);
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. In MEASURE the falling edge is tested before the
    // limit so that an echo ending exactly at the limit is still a valid
    // measurement. GUARD is where a dropped enable takes effect.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (enable && (sensor_mask != '0)) begin
                    state_next = SELECT;
                end
            end
            SELECT: begin
                state_next = sel_found ? TRIG : IDLE;
            end
            TRIG: begin
                if (timer == TRIG_LAST) begin
                    state_next = WAIT_RISE;
                end
            end
            WAIT_RISE: begin
                if (echo_rise) begin
                    state_next = MEASURE;
                end else if (timer >= TIMEOUT_LIM) begin
                    state_next = REPORT;
                end
            end
            MEASURE: begin
                if (echo_fall || (timer >= TIMEOUT_LIM)) begin
                    state_next = REPORT;
                end
            end
            REPORT: begin
                state_next = GUARD;
            end
            GUARD: begin
                if (timer >= GUARD_LAST) begin
                    state_next = enable ? SELECT : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output decode. The trigger vector is computed from the state being
    // entered so that the registered trig_out is high for exactly the
    // cycles spent in TRIG; in SELECT the freshly chosen id is not yet in
    // cur_id, so it is taken straight from the selector.
    always_comb begin
        busy      = (state != IDLE);
        trig_id   = (state == SELECT) ? sel_id : cur_id;
        trig_next = '0;
        if (state_next == TRIG) begin
            trig_next[trig_id] = 1'b1;
        end
    end

    // Datapath: shared timer, sensor bookkeeping and the result registers.
    // Result fields are loaded on the transition into REPORT so they are
    // stable while result_valid is high and hold until the next REPORT.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer          <= '0;
            cur_id         <= '0;
            last_id        <= LAST_INIT;
            trig_out       <= '0;
            result_valid   <= 1'b0;
            result_id      <= '0;
            result_cycles  <= '0;
            result_timeout <= 1'b0;
        end else begin
            trig_out     <= trig_next;
            result_valid <= (state_next == REPORT);
            case (state)
                IDLE: begin
                    timer <= '0;
                end
                SELECT: begin
                    timer <= '0;
                    if (sel_found) begin
                        cur_id  <= sel_id;
                        last_id <= sel_id;
                    end
                end
                TRIG: begin
                    timer <= (timer == TRIG_LAST) ? '0 : timer_inc;
                end
                WAIT_RISE: begin
                    if (echo_rise) begin
                        // The edge cycle is already the first high cycle.
                        timer <= TIMER_ONE;
                    end else if (timer >= TIMEOUT_LIM) begin
                        result_id      <= cur_id;
                        result_cycles  <= '0;
                        result_timeout <= 1'b1;
                    end else begin
                        timer <= timer_inc;
                    end
                end
                MEASURE: begin
                    if (echo_fall) begin
                        result_id      <= cur_id;
                        result_cycles  <= timer;
                        result_timeout <= 1'b0;
                    end else if (timer >= TIMEOUT_LIM) begin
                        result_id      <= cur_id;
                        result_cycles  <= TIMEOUT_LIM;
                        result_timeout <= 1'b1;
                    end else begin
                        timer <= timer_inc;
                    end
                end
                REPORT: begin
                    timer <= '0;
                end
                GUARD: begin
                    timer <= timer_inc;
                end
                default: begin
                    timer <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sonar_scan_scheduler.sv
// ---------------------------------------------------------------------------
// tb_sonar_scan_scheduler
//
// Self-checking bench for sonar_scan_scheduler. Behavioural sensors answer
// each trigger with a (fixed or random) echo; a simple model predicts which
// sensor should be triggered next from the mask and the previous choice,
// and what each reported result must be from the echo that was produced.
// ---------------------------------------------------------------------------
module tb_sonar_scan_scheduler;

    localparam int NUM   = 4;
    localparam int IDW   = 2;
    localparam int CW    = 22;
    localparam int TRIG  = 4;
    localparam int TMO   = 100;
    localparam int GUARD = 20;

    // Sensor behaviour modes.
    localparam int M_FIXED  = 0;
    localparam int M_RANDOM = 1;
    localparam int M_NEVER  = 2;
    localparam int M_STUCK  = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            enable;
    logic [NUM-1:0]  sensor_mask;
    logic [NUM-1:0]  echo_in;
    logic [NUM-1:0]  trig_out;
    logic            result_valid;
    logic [IDW-1:0]  result_id;
    logic [CW-1:0]   result_cycles;
    logic            result_timeout;
    logic            busy;

    sonar_scan_scheduler #(
        .NUM_SENSORS    (NUM),
        .ID_W           (IDW),
        .CNT_W          (CW),
        .TRIG_CYCLES    (TRIG),
        .TIMEOUT_CYCLES (TMO),
        .GUARD_CYCLES   (GUARD)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .sensor_mask    (sensor_mask),
        .echo_in        (echo_in),
        .trig_out       (trig_out),
        .result_valid   (result_valid),
        .result_id      (result_id),
        .result_cycles  (result_cycles),
        .result_timeout (result_timeout),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int cycles;
        int tmo;
        int fallCycle;
        bit chkLat;
    } exp_t;

    int   checkCount = 0;
    int   errCount   = 0;
    int   cycle      = 0;
    int   trigRises  = 0;
    int   resultCount = 0;
    int   modelLast  = NUM - 1;
    bit   abortPing  = 1'b0;
    int   mode[NUM];
    int   cfgDelay[NUM];
    int   cfgWidth[NUM];
    int   riseAt[NUM];
    int   fallAt[NUM];
    int   trigLen[NUM];
    int   trigCount[NUM];
    exp_t expQ[$];

    // Every comparison goes through here.
    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        checkCount++;
        if (observed != expected) begin
            errCount++;
            $display("[TB] FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, observed, expected, cycle);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic [NUM-1:0] mask);
        enable      = en;
        sensor_mask = mask;
    endtask

    // Round-robin reference: first mask bit strictly after the previous pick.
    function automatic int modelNext();
        for (int i = 1; i <= NUM; i++) begin
            int idx;
            idx = (modelLast + i) % NUM;
            if (sensor_mask[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic waitResults(input int n);
        int target;
        int budget;
        target = resultCount + n;
        budget = 400 * n;
        while (resultCount < target && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        checkOutput("results_arrived", (resultCount >= target), 1);
    endtask

    task automatic stopScan();
        int budget;
        applyStimulus(1'b0, sensor_mask);
        budget = 1000;
        while (busy && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        checkOutput("idle_reached", busy, 0);
    endtask

    task automatic pulseReset();
        checkOutput("queue_drained", expQ.size(), 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        modelLast = NUM - 1;
        expQ.delete();
    endtask

    // Behavioural sensors: watch the trigger lines, check trigger shape and
    // order, produce the echo and queue the result that must come back.
    initial begin
        int   nxt;
        int   d;
        int   w;
        exp_t e;
        echo_in = '0;
        for (int s = 0; s < NUM; s++) begin
            riseAt[s]    = 0;
            fallAt[s]    = 0;
            trigLen[s]   = 0;
            trigCount[s] = 0;
        end
        forever begin
            logic [NUM-1:0] prevTrig;
            @(negedge clk);
            cycle++;
            if (trig_out != '0) checkOutput("trig_onehot", $countones(trig_out), 1);
            for (int s = 0; s < NUM; s++) begin
                if (trig_out[s]) trigLen[s]++;
                if (trig_out[s] && !prevTrig[s]) begin
                    trigRises++;
                    trigCount[s]++;
                    nxt = modelNext();
                    checkOutput("trig_id", s, nxt);
                    modelLast = (nxt < 0) ? s : nxt;
                end
                if (!trig_out[s] && prevTrig[s]) begin
                    if (abortPing) begin
                        abortPing = 1'b0;
                    end else begin
                        checkOutput("trig_len", trigLen[s], TRIG);
                        e.id        = s;
                        e.fallCycle = cycle;
                        e.chkLat    = (mode[s] == M_NEVER);
                        if (mode[s] == M_NEVER || mode[s] == M_STUCK) begin
                            e.cycles = 0;
                            e.tmo    = 1;
                        end else begin
                            if (mode[s] == M_FIXED) begin
                                d = cfgDelay[s];
                                w = cfgWidth[s];
                            end else begin
                                d = int'($urandom_range(40, 1));
                                w = int'($urandom_range(95, 1));
                            end
                            riseAt[s] = cycle + d;
                            fallAt[s] = cycle + d + w;
                            e.cycles  = (w <= TMO) ? w : TMO;
                            e.tmo     = (w <= TMO) ? 0 : 1;
                        end
                        expQ.push_back(e);
                    end
                    trigLen[s] = 0;
                end
                prevTrig[s] = trig_out[s];
                echo_in[s]  = (mode[s] == M_STUCK) || (cycle >= riseAt[s] && cycle < fallAt[s]);
            end
        end
    end

    // Scoreboard: every result pulse must match the oldest queued ping.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (result_valid) begin
                resultCount++;
                if (expQ.size() == 0) begin
                    checkOutput("result_unexpected", result_id, -1);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("result_id", result_id, e.id);
                    checkOutput("result_cycles", result_cycles, e.cycles);
                    checkOutput("result_timeout", result_timeout, e.tmo);
                    if (e.chkLat)
                        checkOutput("timeout_latency", (cycle - e.fallCycle >= 98 && cycle - e.fallCycle <= 105), 1);
                end
            end
        end
    end

    initial begin
        #800000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errCount);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int rises;
        int budget;
        int t0;
        int t2;
        rst = 1'b1;
        applyStimulus(1'b0, '0);
        for (int s = 0; s < NUM; s++) begin
            mode[s]     = M_FIXED;
            cfgDelay[s] = 10;
            cfgWidth[s] = 30;
        end
        repeat (3) @(negedge clk);
        checkOutput("reset_trig", trig_out, 0);
        checkOutput("reset_valid", result_valid, 0);
        checkOutput("reset_id", result_id, 0);
        checkOutput("reset_cycles", result_cycles, 0);
        checkOutput("reset_timeout", result_timeout, 0);
        checkOutput("reset_busy", busy, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("idle_while_disabled", busy, 0);

        // Full mask, fixed 30-cycle echoes, then random echoes.
        $display("[TB] full mask scan");
        applyStimulus(1'b1, 4'b1111);
        waitResults(5);
        for (int s = 0; s < NUM; s++) mode[s] = M_RANDOM;
        waitResults(8);
        stopScan();

        // Sparse mask: only sensors 1 and 3 may fire.
        $display("[TB] sparse mask scan");
        t0 = trigCount[0];
        t2 = trigCount[2];
        applyStimulus(1'b1, 4'b1010);
        waitResults(4);
        stopScan();
        checkOutput("sensor0_untouched", trigCount[0] - t0, 0);
        checkOutput("sensor2_untouched", trigCount[2] - t2, 0);

        // Silent sensor 2 must time out without stalling the scan.
        $display("[TB] silent sensor");
        mode[2] = M_NEVER;
        applyStimulus(1'b1, 4'b1111);
        waitResults(6);
        stopScan();
        mode[2] = M_RANDOM;

        // Stuck-high sensor 1 and long / boundary echoes on sensor 0.
        $display("[TB] stuck and long echoes");
        mode[1]     = M_STUCK;
        mode[0]     = M_FIXED;
        cfgDelay[0] = 10;
        cfgWidth[0] = 150;
        pulseReset();
        applyStimulus(1'b1, 4'b0011);
        waitResults(1);
        cfgWidth[0] = 100;
        waitResults(2);
        cfgWidth[0] = 101;
        waitResults(2);
        stopScan();
        mode[1] = M_RANDOM;

        // Enable dropped while sensor 0 is measuring.
        $display("[TB] enable drop mid-measure");
        cfgDelay[0] = 5;
        cfgWidth[0] = 60;
        pulseReset();
        applyStimulus(1'b1, 4'b1111);
        budget = 1000;
        while (!trig_out[0] && budget > 0) begin @(negedge clk); budget--; end
        while (trig_out[0] && budget > 0) begin @(negedge clk); budget--; end
        checkOutput("sensor0_triggered", (budget > 0), 1);
        repeat (20) @(negedge clk);
        applyStimulus(1'b0, 4'b1111);
        budget = 300;
        while (!result_valid && budget > 0) begin @(negedge clk); budget--; end
        checkOutput("drop_result_seen", result_valid, 1);
        repeat (GUARD) @(negedge clk);
        checkOutput("guard_busy", busy, 1);
        @(negedge clk);
        checkOutput("after_guard_idle", busy, 0);
        rises = trigRises;
        repeat (100) @(negedge clk);
        checkOutput("no_trigger_disabled", trigRises - rises, 0);
        checkOutput("still_idle", busy, 0);
        mode[0] = M_RANDOM;
        applyStimulus(1'b1, 4'b1111);
        waitResults(2);

        // Reset pulse in the middle of a trigger.
        $display("[TB] reset mid-trigger");
        budget = 1000;
        while (trig_out == '0 && budget > 0) begin @(negedge clk); budget--; end
        checkOutput("trigger_before_reset", (trig_out != '0), 1);
        repeat (2) @(negedge clk);
        abortPing = 1'b1;
        rst       = 1'b1;
        applyStimulus(1'b1, 4'b0110);
        @(negedge clk);
        checkOutput("reset_drops_trig", trig_out, 0);
        checkOutput("reset_no_valid", result_valid, 0);
        rst       = 1'b0;
        modelLast = NUM - 1;
        expQ.delete();
        waitResults(3);
        stopScan();

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule

// File: doc/sonar_scan_scheduler.md
Name: sonar_scan_scheduler

Overview:
Round-robin scheduler that shares one echo-width timer among NUM_SENSORS ultrasonic rangers on the arm.
For each enabled sensor it:
- issues a trigger pulse;
- times the echo pulse, with a timeout;
- reports the raw width in clock cycles;
- waits a guard interval to suppress cross-talk before the next sensor.
It sits between the sensor pins and the arm motion/collision logic, which converts cycles to distance.

Parameters:
NUM_SENSORS, 4, number of sensors (2..8)
ID_W, 2, width of sensor index (>= clog2(NUM_SENSORS))
CNT_W, 22, width of timer and result
TRIG_CYCLES, 500, trigger high time in clk cycles (10 us at 50 MHz)
TIMEOUT_CYCLES, 1500000, max wait for echo rise and max echo width (30 ms)
GUARD_CYCLES, 3000000, idle gap after each ping (60 ms)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
enable  in  1  scanning allowed
sensor_mask  in  NUM_SENSORS  1 = sensor included in scan
echo_in  in  NUM_SENSORS  raw asynchronous echo pins
trig_out  out  NUM_SENSORS  registered trigger pulses, at most one bit high
result_valid  out  1  one-cycle pulse, result fields valid
result_id  out  ID_W  sensor index of result
result_cycles  out  CNT_W  echo high width in clk cycles
result_timeout  out  1  measurement timed out
busy  out  1  high in every state except IDLE

Behaviour:
- Synchronizer: echo_in passes through a 2-flop synchronizer per bit. Edge detection uses the synchronized value and its 1-cycle delayed copy. Added latency of 2 cycles is accepted and not compensated.
- Reset: all outputs 0, state IDLE, timer 0, last_id = NUM_SENSORS-1 (first selected sensor is the lowest enabled index). Reset mid-operation drops trig_out the next cycle; any in-flight measurement is discarded, with no result_valid.
- IDLE: if enable=1 and sensor_mask != 0, go to SELECT; otherwise stay.
- SELECT (1 cycle):
  - choose first mask bit strictly after last_id, wrapping modulo NUM_SENSORS;
  - store it as cur_id and last_id;
  - if the mask is now 0, go to IDLE.
  - Mask is sampled only here; a sensor with only its own bit set is re-selected every round.
- TRIG:
  - trig_out[cur_id]=1 for exactly TRIG_CYCLES cycles, timer counts 0..TRIG_CYCLES-1;
  - then clear the timer and go to WAIT_RISE.
- WAIT_RISE:
  - timer increments each cycle;
  - rising edge on synced echo[cur_id]: clear timer to 1 (this cycle counts as high), go to MEASURE;
  - timer reaching TIMEOUT_CYCLES: go to REPORT with timeout=1, cycles=0.
  - An echo already high on entry does not count; a rising edge is required, so stuck-high is reported as a timeout.
- MEASURE:
  - timer increments while synced echo is high;
  - falling edge: cycles=timer, timeout=0, go to REPORT;
  - timer reaching TIMEOUT_CYCLES: cycles=TIMEOUT_CYCLES, timeout=1, go to REPORT.
  - If the fall and the limit occur in the same cycle, the fall wins (timeout=0).
- REPORT (1 cycle): result_valid=1. result_id, result_cycles and result_timeout are registered here and hold their value until the next REPORT. Then clear the timer and go to GUARD.
- GUARD: count GUARD_CYCLES cycles, then:
  - if enable=1, go to SELECT;
  - else go to IDLE.
- enable deasserted mid-ping: the current ping completes through REPORT and GUARD; no new sensor is selected.
- Timer saturates; it never wraps. CNT_W must hold max(TIMEOUT_CYCLES, GUARD_CYCLES).
- Echo activity on non-selected sensors is ignored.

Test Plan:
(Bench params: NUM_SENSORS=4, TRIG_CYCLES=4, TIMEOUT_CYCLES=100, GUARD_CYCLES=20.)
1. Mask=4'b1111, enable=1; each sensor echoes high 30 cycles, starting 10 cycles after its trigger ends -> results in id order 0,1,2,3,0; cycles=30, timeout=0; trig_out high exactly 4 cycles, one-hot.
2. Mask=4'b1010 -> trigger/result order 1,3,1,3; sensors 0 and 2 are never triggered.
3. Sensor 2 never echoes -> result id=2, timeout=1, cycles=0, about 100 cycles after its trigger falls; the scan continues to the next sensor.
4. Sensor 1 echo stuck high from reset -> timeout=1, cycles=0. Sensor 0 echo high for 150 cycles -> timeout=1, cycles=100.
5. enable dropped during MEASURE of sensor 0 -> one result for id 0, then 20 guard cycles, then IDLE with busy=0 and no further triggers. Re-enabling resumes at sensor 1.
6. rst asserted for one cycle mid-TRIG -> trig_out=0 the next cycle, no result_valid. After release, the first trigger goes to the lowest enabled sensor.
